// File: rtl/apb_timer_mch.sv
// Multi-channel APB timer: NUM_CH up/down counters with auto-reload, sticky flags and registered irqs.
// Latency: writes land on the access-phase edge, reads are combinational, irq follows its flag by one pclk.
// Backpressure: none; pready is tied high and every access completes in one access phase.
module apb_timer_mch #(
    parameter int CNT_WIDTH = 16,
    parameter int NUM_CH    = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);
    localparam logic [4:0]           NUM_CH_L = 5'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                     access;
    logic                     addr_bad;
    logic                     bus_wr;
    logic                     bus_rd;
    logic [1:0]               reg_sel;
    logic [3:0]               presc;
    logic [NUM_CH-1:0]        ch_hit;
    logic [NUM_CH-1:0][31:0]  rd_word;

    assign access   = psel & penable;
    assign addr_bad = ({1'b0, paddr[7:4]} >= NUM_CH_L) || (paddr[1:0] != 2'b00);
    assign bus_wr   = access & pwrite & ~addr_bad;
    assign bus_rd   = access & ~pwrite & ~addr_bad;
    assign reg_sel  = paddr[3:2];
    assign pready   = 1'b1;
    assign pslverr  = access & addr_bad;

    always_ff @(posedge pclk) begin
        if (preset) begin
            presc <= '0;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    always_comb begin
        prdata = '0;
        if (bus_rd) begin
            for (int n = 0; n < NUM_CH; n++) begin
                prdata = prdata | rd_word[n];
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_WIDTH-1:0] tdr;
        logic [CNT_WIDTH-1:0] tcnt;
        logic [CNT_WIDTH-1:0] tcnt_nxt;
        logic [7:0]           tcr;
        logic [1:0]           tsr;
        logic [1:0]           tsr_set;
        logic [1:0]           tsr_keep;
        logic                 tick;
        logic                 irq_q;
        logic                 wr_ch;

        assign ch_hit[n] = (paddr[7:4] == 4'(n));
        assign wr_ch     = bus_wr & ch_hit[n];

        // A tick fires when the low clk_sel+1 prescaler bits are all ones.
        always_comb begin
            unique case (tcr[1:0])
                2'd0:    tick = presc[0];
                2'd1:    tick = &presc[1:0];
                2'd2:    tick = &presc[2:0];
                default: tick = &presc;
            endcase
        end

        always_comb begin
            tcnt_nxt = tcnt;
            tsr_set  = 2'b00;
            if (tcr[7]) begin
                tcnt_nxt = tdr;
            end else if (tcr[4] && tick) begin
                if (tcr[5]) begin
                    if (tcnt == '0) begin
                        tcnt_nxt   = tcr[6] ? tdr : CNT_MAX;
                        tsr_set[1] = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt - CNT_ONE;
                    end
                end else begin
                    if (tcnt == CNT_MAX) begin
                        tcnt_nxt   = tcr[6] ? tdr : '0;
                        tsr_set[0] = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + CNT_ONE;
                    end
                end
            end
        end

        // Written zeros clear flags; a same-edge set is OR-ed in last so it wins.
        assign tsr_keep = (wr_ch && reg_sel == 2'd2) ? pwdata[1:0] : 2'b11;

        always_ff @(posedge pclk) begin
            if (preset) begin
                tdr   <= '0;
                tcr   <= '0;
                tsr   <= '0;
                tcnt  <= '0;
                irq_q <= 1'b0;
            end else begin
                if (wr_ch && reg_sel == 2'd0) begin
                    tdr <= pwdata[CNT_WIDTH-1:0];
                end
                if (wr_ch && reg_sel == 2'd1) begin
                    tcr <= pwdata[7:0];
                end
                tsr   <= (tsr & tsr_keep) | tsr_set;
                tcnt  <= tcnt_nxt;
                irq_q <= (tsr[0] & tcr[3]) | (tsr[1] & tcr[2]);
            end
        end

        assign irq[n] = irq_q;

        assign rd_word[n] = !ch_hit[n]        ? 32'd0 :
                            (reg_sel == 2'd0) ? 32'(tdr) :
                            (reg_sel == 2'd1) ? {24'd0, tcr} :
                            (reg_sel == 2'd2) ? {30'd0, tsr} :
                                                32'(tcnt);
    end
endmodule

// File: doc/apb_timer_mch.md
Name: apb_timer_mch

Overview:
- Parametrised multi-channel APB timer; successor to the single-channel 8-bit TDR/TCR/TSR timer.
- Provides NUM_CH independent up/down counters of CNT_WIDTH bits, sharing one APB slave port and one prescaler.
- Adds auto-reload mode, a readable live count register, per-channel interrupt enables and a registered interrupt line per channel.
- Sits on the peripheral APB bus next to the existing timer and is driven by the same CPU bus model.

Parameters:
- CNT_WIDTH, 16, counter/TDR width in bits (legal range 2..32).
- NUM_CH, 4, number of channels (legal range 1..8).

Ports:
- pclk  in  1  APB/system clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  8  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  tied to 1; no wait states.
- pslverr  out  1  error response for an unmapped address.
- irq  out  NUM_CH  per-channel interrupt, registered.

Behaviour:
- Address map: channel n base = n*0x10.
  - +0x0 TDR: RW, bits [CNT_WIDTH-1:0].
  - +0x4 TCR: RW, bits [7:0].
  - +0x8 TSR: RW, bits [1:0].
  - +0xC TCNT: RO.
  - Upper unused bits read as 0.
- TCR bits: [7] load, [6] arl (auto-reload), [5] dw (1 = down), [4] en, [3] ovf_ie, [2] udf_ie, [1:0] clk_sel.
- TSR bits: [1] udf, [0] ovf. Writing 0 to a bit clears it; writing 1 has no effect.
- APB write: takes effect on the pclk edge where psel & penable & pwrite are all 1.
- APB read: prdata is combinational from the registers when psel & penable & !pwrite; otherwise prdata = 0.
- pslverr = 1 during the access phase when paddr[7:4] >= NUM_CH or paddr[1:0] != 0.
  - An errored write changes nothing.
  - An errored read returns 0.
  - A write to TCNT is not an error; it is ignored.
- Prescaler: shared free-running 4-bit counter, cleared by reset.
  - Each channel has its own tick: for clk_sel = k, tick = 1 when the low k+1 prescaler bits are all 1.
  - Result: one tick every 2, 4, 8 or 16 pclk.
  - A clk_sel change takes effect on the next cycle, with no resync.
- Counter update, in priority order each pclk edge:
  1. preset: TDR, TCR, TSR, TCNT, prescaler and irq all = 0.
  2. load = 1: TCNT <= TDR every cycle (level-sensitive); no counting and no flag setting.
  3. en = 1 and tick:
     - up, TCNT != max: TCNT + 1.
     - up, TCNT == max: TCNT <= arl ? TDR : 0, and set ovf.
     - down, TCNT != 0: TCNT - 1.
     - down, TCNT == 0: TCNT <= arl ? TDR : max, and set udf.
  4. Otherwise TCNT holds.
  - max = 2^CNT_WIDTH - 1.
- Flags:
  - A flag is set on the same edge the counter wraps.
  - If a set and a software clear of the same bit happen in the same cycle, set wins.
  - Flags are sticky until cleared or reset.
- irq[n]: registered (ovf & ovf_ie) | (udf & udf_ie), one cycle after the flag/enable change. Cleared by reset.
- Writing TDR while load = 1: TCNT follows on the next cycle.
- Changing dw mid-count: direction changes on the next tick, with no reload.
- Clearing en: TCNT freezes immediately; setting en again resumes from the frozen value.
- Reset mid-count: everything returns to 0 on that edge. After release, counting resumes only after TCR is rewritten.
- Channels are fully independent; no cross-channel interaction apart from the shared prescaler phase.

Test Plan:
1. Load and count down: ch0 TDR = 0x00FF, TCR = 0x80 then 0x30, wait 2*220 pclk.
   - Required: TSR = 0; TCNT = 0x00FF - 220 (±1).
   - After 2*256 pclk total: TSR = 0x2, TCNT = 0xFFFF.
   - Write TSR = 0: reads back 0x0.
2. Auto-reload up with interrupt: ch2 TDR = 0xFFF0, TCR = 0x80 then 0x5B (arl, up, en, ovf_ie, clk_sel = 3), wait 16*16 pclk.
   - Required: ovf = 1, TCNT = 0xFFF0.
   - irq[2] rises exactly one cycle after ovf.
   - irq[2] falls one cycle after the TSR clear.
3. Simultaneous set and clear: time a TSR = 0 write to the exact edge of a ch1 underflow.
   - Required: udf reads back as 1.
4. Reset mid-operation: ch0 and ch3 counting, TSR flags set; assert preset for 3 cycles.
   - Required: all registers, prdata-visible state and irq = 0.
   - Write TCR = 0x30 afterwards: ch0 TCNT reaches 0xFFFF with udf set after 2 pclk.
5. Bus errors and isolation (NUM_CH = 4):
   - Read 0x40, or write 0x05: pslverr = 1 and no state change.
   - Write TCNT on ch1: ignored.
   - ch1 activity leaves ch0 TCNT/TSR untouched.
6. Prescaler check: ch0 clk_sel = 0..3 in turn, 10 ticks each.
   - Required: TCNT advances exactly every 2 / 4 / 8 / 16 pclk.
